acp_rd_arbiter: RTL and testbench
=================================

Name: acp_rd_arbiter

Overview:
Two-requester round-robin arbiter that shares the accelerator's 64-bit ACP AXI master read channel (AR/R) between two internal read engines.
- Each requester submits a burst command (address, length).
- The arbiter issues one coherent INCR burst at a time on the ACP port.
- It routes the R beats back to the granted requester until RLAST.
- It sits inside the accelerator, between the read engines and the M_AXI_AR*/R* pins. Write channels are untouched.

Parameters:
ARCACHE_VAL, 4'b1111, driven on M_AXI_ARCACHE (write-back, read/write-allocate, coherent)
ARUSER_VAL, 5'b00001, driven on M_AXI_ARUSER (shared/coherent attribute)
ARPROT_VAL, 3'b000, driven on M_AXI_ARPROT

Ports:
clk  in  1  system clock (FCLK0 domain)
rst  in  1  asynchronous active-high reset
rq0_cmd_valid  in  1  requester 0 burst command valid
rq0_cmd_ready  out  1  requester 0 command accepted
rq0_cmd_addr  in  32  requester 0 byte address, 8-byte aligned
rq0_cmd_len  in  8  requester 0 beats minus one (AXI ARLEN encoding)
rq1_cmd_valid / rq1_cmd_ready / rq1_cmd_addr / rq1_cmd_len  same as requester 0, for requester 1
rd_data  out  64  read beat data, shared by both requesters
rd_last  out  1  last beat of burst, shared
rd_resp  out  2  RRESP of beat, shared
rq0_rd_valid / rq1_rd_valid  out  1  beat valid, per requester
rq0_rd_ready / rq1_rd_ready  in  1  beat ready, per requester
M_AXI_ARADDR  out  32
M_AXI_ARLEN  out  8
M_AXI_ARSIZE  out  3  constant 3'b011
M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
M_AXI_ARCACHE  out  4
M_AXI_ARUSER  out  5
M_AXI_ARPROT  out  3
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  64
M_AXI_RRESP  in  2
M_AXI_RLAST  in  1
M_AXI_RVALID  in  1
M_AXI_RREADY  out  1

Behaviour:
- Clocking and reset: one clock, clk. Reset (rst) is asynchronous and active-high.
- Reset values: state IDLE; M_AXI_ARVALID=0; M_AXI_ARADDR=0; M_AXI_ARLEN=0; last_grant=1, so requester 0 wins first.
- Every output is combinational from state and grant. In reset all valid/ready outputs are therefore 0 and the rd_* buses are 0.
- States: IDLE, ADDR, DATA. Only one transaction is outstanding at a time.
- IDLE, winner selection:
  - Only one requester valid: that requester wins.
  - Both valid: the requester that is not last_grant wins.
- IDLE, acceptance: rqN_cmd_ready=1 combinationally for the winner only. On the handshake:
  - Register addr/len into ARADDR/ARLEN.
  - Record grant=N.
  - Go to ADDR. ARVALID rises the next cycle (1-cycle command-to-AR latency).
- ADDR: ARVALID held high with stable address/len until ARREADY. On ARVALID&ARREADY, ARVALID drops in the same edge and state goes to DATA.
- DATA, routing:
  - rqN_rd_valid = RVALID for the granted N; 0 for the other requester.
  - RREADY = rqN_rd_ready of the granted N.
  - rd_data/rd_last/rd_resp = RDATA/RLAST/RRESP.
- DATA, completion: on RVALID&RREADY&RLAST, set last_grant=grant and go to IDLE. A new command can be accepted the cycle after RLAST (no dead cycle beyond that).
- Outside DATA: RREADY=0 and both rqN_rd_valid=0. Stray R beats are never acknowledged.
- Error responses: a beat with RRESP≠OKAY is forwarded unchanged via rd_resp. The burst still runs to RLAST; no abort.
- Beat count: the arbiter does not count beats. RLAST alone ends the burst.
- 4 KB boundary and alignment: the requester's responsibility. The arbiter neither checks nor splits.
- Command stability: a requester must hold cmd_valid/addr/len until ready. Withdrawal before ready is tolerated; no grant is recorded.
- Reset mid-operation: immediate return to IDLE. rst must accompany the PS fabric reset so the ACP port is also idle.

Optional Feature:
ACP_RD_ARB_STATS_EN
- Defined:
  - Adds outputs rq0_burst_cnt[15:0] and rq1_burst_cnt[15:0].
  - Each increments on its requester's RLAST handshake and saturates at 16'hFFFF.
  - Adds output rd_err_sticky: set on any beat with RRESP≠OKAY, cleared only by rst.
  - All three reset to 0.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Single command rq0 addr=0x1000_0000 len=3, ARREADY same cycle as ARVALID, 4 beats with rd_ready=1 → ARVALID one cycle after cmd handshake with ARADDR=0x1000_0000, ARLEN=3, ARSIZE=3, ARBURST=1, ARCACHE=4'hF, ARUSER=5'h01; rq0_rd_valid 4 beats; rq1_rd_valid never high.
- rq0 and rq1 valid simultaneously, continuously, 3 rounds of len=0 → grant order 0,1,0,1,0,1.
- ARREADY held low for 5 cycles → ARVALID/ARADDR/ARLEN stable for 6 cycles; no cmd_ready pulses meanwhile.
- rq1 rd_ready toggled 1,0,0,1 during an 8-beat burst → RREADY mirrors it exactly; no beat lost or duplicated.
- Beat 2 of 4 returns RRESP=2'b10 → rd_resp=2 on that beat only; burst completes; rd_err_sticky=1 when ACP_RD_ARB_STATS_EN is defined.
- rst asserted in DATA mid-burst → next cycle state IDLE, RREADY=0, ARVALID=0; after release, rq0 wins a contested first grant.

Source files
------------

// File: rtl/acp_rd_arbiter.sv
// Round-robin arbiter sharing the ACP AXI read channel between two read engines.
// Optional burst/error statistics are enabled with ACP_RD_ARB_STATS_EN.
module acp_rd_arbiter #(
  parameter logic [3:0] ARCACHE_VAL = 4'b1111,
  parameter logic [4:0] ARUSER_VAL  = 5'b00001,
  parameter logic [2:0] ARPROT_VAL  = 3'b000
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        rq0_cmd_valid,
  output logic        rq0_cmd_ready,
  input  logic [31:0] rq0_cmd_addr,
  input  logic [7:0]  rq0_cmd_len,

  input  logic        rq1_cmd_valid,
  output logic        rq1_cmd_ready,
  input  logic [31:0] rq1_cmd_addr,
  input  logic [7:0]  rq1_cmd_len,

  output logic [63:0] rd_data,
  output logic        rd_last,
  output logic [1:0]  rd_resp,
  output logic        rq0_rd_valid,
  output logic        rq1_rd_valid,
  input  logic        rq0_rd_ready,
  input  logic        rq1_rd_ready,

`ifdef ACP_RD_ARB_STATS_EN
  output logic [15:0] rq0_burst_cnt,
  output logic [15:0] rq1_burst_cnt,
  output logic        rd_err_sticky,
`endif

  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [4:0]  M_AXI_ARUSER,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;

  logic        win0, win1;
  logic        beat_hs;
  logic        last_hs;

  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = ARCACHE_VAL;
  assign M_AXI_ARUSER  = ARUSER_VAL;
  assign M_AXI_ARPROT  = ARPROT_VAL;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;

  // On contention the requester that did not win last time gets the grant.
  assign win0 = rq0_cmd_valid && (!rq1_cmd_valid || last_grant_q);
  assign win1 = rq1_cmd_valid && (!rq0_cmd_valid || !last_grant_q);

  always_comb begin
    state_d       = state_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    rq0_cmd_ready = 1'b0;
    rq1_cmd_ready = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rq0_rd_valid  = 1'b0;
    rq1_rd_valid  = 1'b0;
    rd_data       = 64'd0;
    rd_last       = 1'b0;
    rd_resp       = 2'b00;
    beat_hs       = 1'b0;
    last_hs       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Hold off acceptance while reset is asserted.
        rq0_cmd_ready = win0 && !rst;
        rq1_cmd_ready = win1 && !rst;
        if (win0) begin
          araddr_d = rq0_cmd_addr;
          arlen_d  = rq0_cmd_len;
          grant_d  = 1'b0;
          state_d  = ADDR;
        end else if (win1) begin
          araddr_d = rq1_cmd_addr;
          arlen_d  = rq1_cmd_len;
          grant_d  = 1'b1;
          state_d  = ADDR;
        end
      end

      ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = DATA;
        end
      end

      DATA: begin
        M_AXI_RREADY = grant_q ? rq1_rd_ready : rq0_rd_ready;
        rq0_rd_valid = M_AXI_RVALID && !grant_q;
        rq1_rd_valid = M_AXI_RVALID && grant_q;
        rd_data      = M_AXI_RDATA;
        rd_last      = M_AXI_RLAST;
        rd_resp      = M_AXI_RRESP;
        beat_hs      = M_AXI_RVALID && M_AXI_RREADY;
        last_hs      = beat_hs && M_AXI_RLAST;
        if (last_hs) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      araddr_q     <= 32'd0;
      arlen_q      <= 8'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef ACP_RD_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic        err_q, err_d;

  // Burst counters saturate rather than wrap.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    err_d  = err_q;
    if (last_hs && !grant_q && cnt0_q != 16'hFFFF) begin
      cnt0_d = cnt0_q + 16'd1;
    end
    if (last_hs && grant_q && cnt1_q != 16'hFFFF) begin
      cnt1_d = cnt1_q + 16'd1;
    end
    if (beat_hs && M_AXI_RRESP != 2'b00) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      err_q  <= err_d;
    end
  end

  assign rq0_burst_cnt = cnt0_q;
  assign rq1_burst_cnt = cnt1_q;
  assign rd_err_sticky = err_q;
`endif

endmodule

// File: tb/tb_acp_rd_arbiter.sv
// Directed self-checking bench for acp_rd_arbiter.
// Stats checks are compiled in when ACP_RD_ARB_STATS_EN is defined.
module tb_acp_rd_arbiter;

  logic        clk;
  logic        rst;
  logic        rq0_cmd_valid, rq0_cmd_ready;
  logic [31:0] rq0_cmd_addr;
  logic [7:0]  rq0_cmd_len;
  logic        rq1_cmd_valid, rq1_cmd_ready;
  logic [31:0] rq1_cmd_addr;
  logic [7:0]  rq1_cmd_len;
  logic [63:0] rd_data;
  logic        rd_last;
  logic [1:0]  rd_resp;
  logic        rq0_rd_valid, rq1_rd_valid;
  logic        rq0_rd_ready, rq1_rd_ready;
`ifdef ACP_RD_ARB_STATS_EN
  logic [15:0] rq0_burst_cnt, rq1_burst_cnt;
  logic        rd_err_sticky;
`endif
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic [4:0]  M_AXI_ARUSER;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  int total;
  int bad;

  acp_rd_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .rq0_cmd_valid (rq0_cmd_valid),
    .rq0_cmd_ready (rq0_cmd_ready),
    .rq0_cmd_addr  (rq0_cmd_addr),
    .rq0_cmd_len   (rq0_cmd_len),
    .rq1_cmd_valid (rq1_cmd_valid),
    .rq1_cmd_ready (rq1_cmd_ready),
    .rq1_cmd_addr  (rq1_cmd_addr),
    .rq1_cmd_len   (rq1_cmd_len),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .rd_resp       (rd_resp),
    .rq0_rd_valid  (rq0_rd_valid),
    .rq1_rd_valid  (rq1_rd_valid),
    .rq0_rd_ready  (rq0_rd_ready),
    .rq1_rd_ready  (rq1_rd_ready),
`ifdef ACP_RD_ARB_STATS_EN
    .rq0_burst_cnt (rq0_burst_cnt),
    .rq1_burst_cnt (rq1_burst_cnt),
    .rd_err_sticky (rd_err_sticky),
`endif
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_ARSIZE  (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST),
    .M_AXI_ARCACHE (M_AXI_ARCACHE),
    .M_AXI_ARUSER  (M_AXI_ARUSER),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic pat [4];
  int   b;
  int   c;
  logic exp_g;

  initial begin
    total = 0;
    bad   = 0;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    rq0_cmd_valid = 1'b0; rq0_cmd_addr = '0; rq0_cmd_len = '0;
    rq1_cmd_valid = 1'b0; rq1_cmd_addr = '0; rq1_cmd_len = '0;
    rq0_rd_ready = 1'b0; rq1_rd_ready = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
    M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;

    // Reset: outputs idle even with requests and stray beats present
    step();
    rq0_cmd_valid = 1'b1;
    rq1_cmd_valid = 1'b1;
    M_AXI_RVALID  = 1'b1;
    M_AXI_RDATA   = 64'hDEAD_BEEF;
    rq0_rd_ready  = 1'b1;
    settle();
    chk("rst_rdy0", rq0_cmd_ready, 0);
    chk("rst_rdy1", rq1_cmd_ready, 0);
    chk("rst_arvalid", M_AXI_ARVALID, 0);
    chk("rst_araddr", M_AXI_ARADDR, 0);
    chk("rst_arlen", M_AXI_ARLEN, 0);
    chk("rst_rready", M_AXI_RREADY, 0);
    chk("rst_rdvalid0", rq0_rd_valid, 0);
    chk("rst_rddata", rd_data, 0);
`ifdef ACP_RD_ARB_STATS_EN
    chk("rst_cnt0", rq0_burst_cnt, 0);
    chk("rst_err", rd_err_sticky, 0);
`endif
    rq0_cmd_valid = 1'b0;
    rq1_cmd_valid = 1'b0;
    M_AXI_RVALID  = 1'b0;
    rq0_rd_ready  = 1'b0;
    step();
    rst = 1'b0;

    // Single rq0 burst, len=3
    rq0_cmd_valid = 1'b1;
    rq0_cmd_addr  = 32'h1000_0000;
    rq0_cmd_len   = 8'd3;
    M_AXI_ARREADY = 1'b1;
    settle();
    chk("t1_rdy0", rq0_cmd_ready, 1);
    chk("t1_rdy1", rq1_cmd_ready, 0);
    chk("t1_arvalid_idle", M_AXI_ARVALID, 0);
    step();
    rq0_cmd_valid = 1'b0;
    settle();
    chk("t1_arvalid", M_AXI_ARVALID, 1);
    chk("t1_araddr", M_AXI_ARADDR, 32'h1000_0000);
    chk("t1_arlen", M_AXI_ARLEN, 3);
    chk("t1_arsize", M_AXI_ARSIZE, 3);
    chk("t1_arburst", M_AXI_ARBURST, 1);
    chk("t1_arcache", M_AXI_ARCACHE, 4'hF);
    chk("t1_aruser", M_AXI_ARUSER, 5'h01);
    chk("t1_arprot", M_AXI_ARPROT, 0);
    chk("t1_rdy0_addr", rq0_cmd_ready, 0);
    step();
    settle();
    chk("t1_arvalid_data", M_AXI_ARVALID, 0);
    for (int i = 0; i < 4; i++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 64'hA0 + 64'(i);
      M_AXI_RLAST  = (i == 3);
      rq0_rd_ready = 1'b1;
      settle();
      chk("t1_rdvalid0", rq0_rd_valid, 1);
      chk("t1_rdvalid1", rq1_rd_valid, 0);
      chk("t1_rddata", rd_data, 64'hA0 + 64'(i));
      chk("t1_rdlast", rd_last, (i == 3));
      chk("t1_rready", M_AXI_RREADY, 1);
      step();
    end
    settle();
    chk("t1_stray_rready", M_AXI_RREADY, 0);
    chk("t1_stray_rdvalid0", rq0_rd_valid, 0);
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;

    // Contested requests alternate starting with rq0
    apply_reset();
    rq0_cmd_valid = 1'b1; rq0_cmd_addr = 32'h100; rq0_cmd_len = 8'd0;
    rq1_cmd_valid = 1'b1; rq1_cmd_addr = 32'h200; rq1_cmd_len = 8'd0;
    rq0_rd_ready  = 1'b1; rq1_rd_ready = 1'b1;
    M_AXI_ARREADY = 1'b1;
    for (int r = 0; r < 6; r++) begin
      exp_g = (r % 2 == 1);
      settle();
      chk("t2_rdy0", rq0_cmd_ready, !exp_g);
      chk("t2_rdy1", rq1_cmd_ready, exp_g);
      step();
      settle();
      chk("t2_araddr", M_AXI_ARADDR, exp_g ? 32'h200 : 32'h100);
      step();
      M_AXI_RVALID = 1'b1;
      M_AXI_RLAST  = 1'b1;
      settle();
      chk("t2_rdvalid0", rq0_rd_valid, !exp_g);
      chk("t2_rdvalid1", rq1_rd_valid, exp_g);
      step();
      M_AXI_RVALID = 1'b0;
      M_AXI_RLAST  = 1'b0;
    end
    rq0_cmd_valid = 1'b0;
    rq1_cmd_valid = 1'b0;

    // ARREADY low for 5 cycles: AR stable, no command acceptance
    rq0_cmd_valid = 1'b1;
    rq0_cmd_addr  = 32'h2000_0040;
    rq0_cmd_len   = 8'd7;
    M_AXI_ARREADY = 1'b0;
    settle();
    chk("t3_rdy0", rq0_cmd_ready, 1);
    step();
    rq1_cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) M_AXI_ARREADY = 1'b1;
      settle();
      chk("t3_arvalid", M_AXI_ARVALID, 1);
      chk("t3_araddr", M_AXI_ARADDR, 32'h2000_0040);
      chk("t3_arlen", M_AXI_ARLEN, 7);
      chk("t3_rdy0_hold", rq0_cmd_ready, 0);
      chk("t3_rdy1_hold", rq1_cmd_ready, 0);
      step();
    end
    rq0_cmd_valid = 1'b0;
    rq1_cmd_valid = 1'b0;
    M_AXI_RVALID  = 1'b1;
    M_AXI_RLAST   = 1'b1;
    settle();
    chk("t3_arvalid_drop", M_AXI_ARVALID, 0);
    chk("t3_rdvalid0", rq0_rd_valid, 1);
    step();
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;

    // rq1 8-beat burst with rd_ready pattern 1,0,0,1
    rq1_cmd_valid = 1'b1;
    rq1_cmd_addr  = 32'h3000_0000;
    rq1_cmd_len   = 8'd7;
    settle();
    chk("t4_rdy1", rq1_cmd_ready, 1);
    step();
    rq1_cmd_valid = 1'b0;
    step();
    b = 0;
    c = 0;
    while (b < 8 && c < 40) begin
      rq1_rd_ready = pat[c % 4];
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 64'hB000 + 64'(b);
      M_AXI_RLAST  = (b == 7);
      settle();
      chk("t4_rready", M_AXI_RREADY, pat[c % 4]);
      chk("t4_rddata", rd_data, 64'hB000 + 64'(b));
      chk("t4_rdvalid1", rq1_rd_valid, 1);
      chk("t4_rdvalid0", rq0_rd_valid, 0);
      if (pat[c % 4]) b++;
      c++;
      step();
    end
    chk("t4_beats", b, 8);
    chk("t4_cycles", c, 16);
    rq1_rd_ready = 1'b1;
    settle();
    chk("t4_idle_rready", M_AXI_RREADY, 0);
    chk("t4_idle_rdvalid1", rq1_rd_valid, 0);
`ifdef ACP_RD_ARB_STATS_EN
    chk("t4_err_clear", rd_err_sticky, 0);
`endif
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;

    // Error response on beat 2 of 4
    rq0_cmd_valid = 1'b1;
    rq0_cmd_addr  = 32'h4000_0000;
    rq0_cmd_len   = 8'd3;
    rq0_rd_ready  = 1'b1;
    settle();
    chk("t5_rdy0", rq0_cmd_ready, 1);
    step();
    rq0_cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RRESP  = (i == 1) ? 2'b10 : 2'b00;
      M_AXI_RLAST  = (i == 3);
      settle();
      chk("t5_rdresp", rd_resp, (i == 1) ? 2 : 0);
      chk("t5_rdvalid0", rq0_rd_valid, 1);
      step();
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RRESP  = 2'b00;
    M_AXI_RLAST  = 1'b0;
    rq0_cmd_valid = 1'b1;
    settle();
    chk("t5_back_idle", rq0_cmd_ready, 1);
`ifdef ACP_RD_ARB_STATS_EN
    chk("t5_err", rd_err_sticky, 1);
    chk("t5_cnt0", rq0_burst_cnt, 5);
    chk("t5_cnt1", rq1_burst_cnt, 4);
`endif

    // Reset mid-burst
    step();
    rq0_cmd_valid = 1'b0;
    step();
    M_AXI_RVALID = 1'b1;
    M_AXI_RLAST  = 1'b0;
    settle();
    chk("t6_rready_pre", M_AXI_RREADY, 1);
    step();
    rst = 1'b1;
    settle();
    chk("t6_rready_async", M_AXI_RREADY, 0);
    chk("t6_arvalid_async", M_AXI_ARVALID, 0);
    step();
    chk("t6_rready", M_AXI_RREADY, 0);
    chk("t6_arvalid", M_AXI_ARVALID, 0);
    chk("t6_rdvalid0", rq0_rd_valid, 0);
    rst = 1'b0;
    M_AXI_RVALID  = 1'b0;
    rq0_cmd_valid = 1'b1;
    rq1_cmd_valid = 1'b1;
    settle();
    chk("t6_rdy0", rq0_cmd_ready, 1);
    chk("t6_rdy1", rq1_cmd_ready, 0);
`ifdef ACP_RD_ARB_STATS_EN
    chk("t6_cnt0", rq0_burst_cnt, 0);
    chk("t6_err", rd_err_sticky, 0);
`endif
    step();
    rq0_cmd_valid = 1'b0;
    rq1_cmd_valid = 1'b0;
    settle();
    chk("t6_araddr", M_AXI_ARADDR, 32'h4000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
